// File: rtl/mont_pkg.sv
// Shared constants, FSM state encoding and word-split helper for the Montgomery sequencer/kernel pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mont_pkg;
  localparam int N       = 6;              // operand width and iteration count
  localparam int W       = 3;              // kernel word width
  localparam int E       = 3;              // words per partial sum
  localparam int SW      = E * W;          // partial-sum width
  localparam int TIMEOUT = 64;             // max cycles waiting for k_done
  localparam int IW      = $clog2(N + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    REDUCE,
    DONE
  } state_e;

  typedef logic [E-1:0][W-1:0] words_t;

  // Split a partial sum into W-bit words, word 0 holding the LSBs.
  function automatic words_t split_words(input logic [SW-1:0] v);
    words_t w;
    for (int k = 0; k < E; k++) begin
      w[k] = v[k*W +: W];
    end
    return w;
  endfunction
endpackage

// File: rtl/mont_sequencer_if.sv
// Host-side operand/result handshakes plus the kernel launch/collect bus of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on operands and result; kernel uses start/done pulses.
interface mont_sequencer_if;
  import mont_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x_in;
  logic [N-1:0]  y_in;
  logic [N-1:0]  m_in;
  logic          k_start;
  logic          k_xi;
  logic [N-1:0]  k_y;
  logic [N-1:0]  k_m;
  logic [SW-1:0] k_s;
  logic          k_done;
  logic [SW-1:0] k_s_new;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;
  logic          err;

  // master: the sequencer (drives the kernel and the result port)
  modport master (
    input  in_valid, x_in, y_in, m_in, k_done, k_s_new, out_ready,
    output in_ready, k_start, k_xi, k_y, k_m, k_s, out_valid, result, err
  );

  // slave: host plus kernel seen from the far side
  modport slave (
    output in_valid, x_in, y_in, m_in, k_done, k_s_new, out_ready,
    input  in_ready, k_start, k_xi, k_y, k_m, k_s, out_valid, result, err
  );
endinterface

// File: rtl/mont_final_sub.sv
// Final Montgomery correction: result = (S >= M) ? S - M : S, truncated to N bits.
// Latency: combinational.
// Backpressure: none. Ports: s_i partial sum (SW), m_i modulus (N), res_o reduced value (N).
module mont_final_sub
  import mont_pkg::*;
(
  input  logic [SW-1:0] s_i,
  input  logic [N-1:0]  m_i,
  output logic [N-1:0]  res_o
);
  logic [SW-1:0] m_ext;
  logic [SW-1:0] diff;
  logic          unused_diff_hi;

  always_comb begin
    m_ext = {{(SW-N){1'b0}}, m_i};
    diff  = s_i - m_ext;
    // Only the low N bits survive; an out-of-range operand pair simply truncates.
    res_o = (s_i >= m_ext) ? diff[N-1:0] : s_i[N-1:0];
  end

  assign unused_diff_hi = ^diff[SW-1:N];
endmodule

// File: rtl/mont_sequencer.sv
// Sequences N bit-serial Montgomery kernel iterations over a latched (X,Y,M) and reduces the sum.
// Latency: 1 + N*(1+L) + 1 cycles accept->out_valid for kernel latency L; 1 cycle for even M.
// Backpressure: in_ready only in IDLE; result/err held in DONE until out_ready. Ports: clk, rst_n, bus (master).
module mont_sequencer
  import mont_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  mont_sequencer_if.master bus
);
  localparam logic [IW-1:0] I_LAST   = IW'(N - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q;
  logic [N-1:0]  x_q;       // shifts right once per iteration; bit 0 is the next xi
  logic [N-1:0]  y_q;
  logic [N-1:0]  m_q;
  logic [SW-1:0] s_q;
  logic [IW-1:0] i_q;
  logic [TW-1:0] tmo_q;
  logic          in_ready_q;
  logic          k_start_q;
  logic          k_xi_q;
  logic          out_valid_q;
  logic [N-1:0]  result_q;
  logic          err_q;
  logic [N-1:0]  sub_res;

  mont_final_sub u_final_sub (
    .s_i   (s_q),
    .m_i   (m_q),
    .res_o (sub_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      m_q         <= '0;
      s_q         <= '0;
      i_q         <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b1;
      k_start_q   <= 1'b0;
      k_xi_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      k_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            x_q        <= bus.x_in;
            y_q        <= bus.y_in;
            m_q        <= bus.m_in;
            s_q        <= '0;
            i_q        <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          // M==0 is covered by the even test.
          if (!m_q[0]) begin
            err_q       <= 1'b1;
            result_q    <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_start_q <= 1'b1;
            k_xi_q    <= x_q[0];
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // k_done wins over a timeout landing in the same cycle.
          if (bus.k_done) begin
            s_q   <= bus.k_s_new;
            i_q   <= i_q + IW'(1);
            tmo_q <= '0;
            x_q   <= x_q >> 1;
            if (i_q == I_LAST) begin
              state_q <= REDUCE;
            end else begin
              k_start_q <= 1'b1;
              k_xi_q    <= x_q[1];
              state_q   <= ISSUE;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_q       <= 1'b1;
            result_q    <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        REDUCE: begin
          result_q    <= sub_res;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.k_start   = k_start_q;
  assign bus.k_xi      = k_xi_q;
  assign bus.k_y       = y_q;
  assign bus.k_m       = m_q;
  assign bus.k_s       = s_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mont_sequencer.sv
// Directed bench for mont_sequencer with a behavioural kernel of programmable latency.
// Latency: n/a.
// Backpressure: exercises out_ready hold-off and in_ready re-raise.
module tb_mont_sequencer;
  import mont_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mont_sequencer_if bus ();

  mont_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Behavioural kernel: k_done arrives lat cycles after the k_start cycle.
  int            lat           = 3;
  int            withhold_iter = -1;   // 1-based iteration whose k_done is never returned
  int            kstart_cnt    = 0;
  int            nonzero_snew  = 0;
  logic [N-1:0]  xi_log        = '0;
  logic          inject        = 1'b0;
  logic          pend          = 1'b0;
  int            cnt           = 0;
  logic          st_s, xi_s, p_xi;
  logic [SW-1:0] s_s, p_s, sum;

  always @(posedge clk) begin
    st_s = bus.k_start;
    xi_s = bus.k_xi;
    s_s  = bus.k_s;
    #1;
    bus.k_done = inject;
    if (st_s === 1'b1) begin
      if (kstart_cnt < N) xi_log[kstart_cnt] = xi_s;
      kstart_cnt++;
      pend = 1'b1;
      cnt  = lat - 1;
      p_xi = xi_s;
      p_s  = s_s;
    end else if (pend) begin
      cnt--;
    end
    if (pend && cnt <= 0) begin
      pend = 1'b0;
      if (kstart_cnt != withhold_iter) begin
        sum = p_s + (p_xi ? SW'(bus.k_y) : SW'(0));
        if (sum[0]) sum = sum + SW'(bus.k_m);
        bus.k_s_new = sum >> 1;
        bus.k_done  = 1'b1;
        if ((sum >> 1) != 0) nonzero_snew++;
      end
    end
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] m);
    @(negedge clk);
    check("rdy_before_send", bus.in_ready, 1);
    bus.x_in     = x;
    bus.y_in     = y;
    bus.m_in     = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Edges from the accept edge until out_valid is seen (0 = same cycle as CHECK).
  task automatic wait_out(output int l);
    l = 0;
    while (bus.out_valid !== 1'b1 && l < 500) begin
      @(negedge clk);
      l++;
    end
    if (bus.out_valid !== 1'b1) check("wait_out_timeout", 0, 1);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hs_out_valid", bus.out_valid, 0);
    check("hs_in_ready", bus.in_ready, 1);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);   // k_done was sampled at the edge before this one
  endtask

  typedef struct {
    logic [N-1:0] x, y, m;
    int           l;
    logic [N-1:0] res;
    int           lat_exp;
  } vec_t;

  vec_t vecs[3] = '{
    '{x: 6'd5, y: 6'd7, m: 6'd13, l: 3, res: 6'd4,  lat_exp: 26},
    '{x: 6'd1, y: 6'd1, m: 6'd13, l: 1, res: 6'd12, lat_exp: 14},
    '{x: 6'd0, y: 6'd9, m: 6'd13, l: 2, res: 6'd0,  lat_exp: 20}
  };

  initial begin
    int l;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.m_in      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_k_start", bus.k_start, 0);
    check("rst_err", bus.err, 0);
    check("rst_result", bus.result, 0);

    // Odd-modulus products
    foreach (vecs[v]) begin
      lat          = vecs[v].l;
      kstart_cnt   = 0;
      nonzero_snew = 0;
      xi_log       = '0;
      send(vecs[v].x, vecs[v].y, vecs[v].m);
      check("busy_in_ready", bus.in_ready, 0);
      wait_out(l);
      check("latency", l, vecs[v].lat_exp);
      check("kstart_count", kstart_cnt, N);
      check("xi_sequence", xi_log, vecs[v].x);
      check("result", bus.result, vecs[v].res);
      check("err", bus.err, 0);
      if (v == 0) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("hold_out_valid", bus.out_valid, 1);
          check("hold_result", bus.result, 4);
          check("hold_in_ready", bus.in_ready, 0);
        end
      end
      if (v == 2) check("zero_snew", nonzero_snew, 0);
      handshake();
    end

    // Even modulus: rejected without touching the kernel
    kstart_cnt = 0;
    send(6'd5, 6'd7, 6'd12);
    wait_out(l);
    check("even_latency", l, 1);
    check("even_err", bus.err, 1);
    check("even_result", bus.result, 0);
    check("even_kstart", kstart_cnt, 0);
    handshake();

    // Kernel timeout on the third iteration
    lat           = 3;
    kstart_cnt    = 0;
    withhold_iter = 3;
    send(6'd5, 6'd7, 6'd13);
    wait_out(l);
    check("tmo_latency", l, 1 + 2 * 4 + 1 + TIMEOUT);
    check("tmo_err", bus.err, 1);
    check("tmo_result", bus.result, 0);
    check("tmo_kstart", kstart_cnt, 3);
    withhold_iter = -1;
    pulse_done();
    check("late_done_out_valid", bus.out_valid, 1);
    check("late_done_err", bus.err, 1);
    check("late_done_result", bus.result, 0);
    handshake();
    pulse_done();
    check("idle_done_in_ready", bus.in_ready, 1);
    check("idle_done_out_valid", bus.out_valid, 0);
    check("idle_done_kstart", kstart_cnt, 3);

    // Reset during WAIT of iteration 2, with the pending k_done landing inside reset
    kstart_cnt = 0;
    send(6'd5, 6'd7, 6'd13);
    l = 0;
    while (kstart_cnt < 2 && l < 100) begin
      @(negedge clk);
      l++;
    end
    check("reached_iter2", kstart_cnt, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_k_start", bus.k_start, 0);
    check("midrst_k_s", bus.k_s, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_in_ready", bus.in_ready, 1);
    check("postrst_out_valid", bus.out_valid, 0);
    kstart_cnt = 0;
    send(6'd5, 6'd7, 6'd13);
    wait_out(l);
    check("rerun_latency", l, 26);
    check("rerun_result", bus.result, 4);
    check("rerun_err", bus.err, 0);
    check("rerun_kstart", kstart_cnt, N);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
